// File: rtl/game_state_ctrl.sv
// Frame-rate game flow controller: start screen, play, pause and game-over,
// with mouse click detection, a per-round play-frame score and a game-over hold-off.
module game_state_ctrl #(
  parameter logic [9:0]  START_X0 = 10'd240,
  parameter logic [9:0]  START_X1 = 10'd399,
  parameter logic [9:0]  START_Y0 = 10'd200,
  parameter logic [9:0]  START_Y1 = 10'd279,
  parameter logic [15:0] GO_HOLD  = 16'd180
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        leftButton,
  input  logic        rightButton,
  input  logic [9:0]  mouse_x,
  input  logic [9:0]  mouse_y,
  input  logic        player_hit,
  output logic        start_signal,
  output logic        ingame_signal,
  output logic        gameover_signal,
  output logic        paused,
  output logic        game_rst,
  output logic [15:0] play_frames
);

  typedef enum logic [1:0] {ST_START, ST_PLAY, ST_PAUSE, ST_OVER} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_left_q;
  logic        r_right_q;
  logic [15:0] r_hold;
  logic [15:0] w_hold_nxt;
  logic [15:0] r_play_frames;
  logic [15:0] w_play_nxt;
  logic        r_game_rst;
  logic        w_game_rst_nxt;
  logic        r_start;
  logic        r_ingame;
  logic        r_over;
  logic        r_paused;
  logic        w_lclick;
  logic        w_rclick;
  logic        w_in_box;

  assign w_lclick = leftButton & ~r_left_q;
  assign w_rclick = rightButton & ~r_right_q;
  assign w_in_box = (mouse_x >= START_X0) && (mouse_x <= START_X1) &&
                    (mouse_y >= START_Y0) && (mouse_y <= START_Y1);

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_play_nxt     = r_play_frames;
    w_game_rst_nxt = 1'b0;
    case (r_state)
      ST_START: begin
        if (w_lclick && w_in_box) begin
          w_state_nxt    = ST_PLAY;
          w_play_nxt     = 16'd0;
          w_game_rst_nxt = 1'b1;
        end
      end
      ST_PLAY: begin
        if (r_play_frames != 16'hFFFF) w_play_nxt = r_play_frames + 16'd1;
        // A hit ends the round even if the player also asked to pause.
        if (player_hit) begin
          w_state_nxt = ST_OVER;
          w_hold_nxt  = 16'd0;
        end else if (w_rclick) begin
          w_state_nxt = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_rclick) w_state_nxt = ST_PLAY;
      end
      ST_OVER: begin
        if (w_lclick && (r_hold == GO_HOLD)) w_state_nxt = ST_START;
        else if (r_hold < GO_HOLD)         w_hold_nxt  = r_hold + 16'd1;
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  // Edge flops reset high so a button held through reset release is not a click.
  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_START;
      r_left_q      <= 1'b1;
      r_right_q     <= 1'b1;
      r_hold        <= 16'd0;
      r_play_frames <= 16'd0;
      r_game_rst    <= 1'b0;
      r_start       <= 1'b1;
      r_ingame      <= 1'b0;
      r_over        <= 1'b0;
      r_paused      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_left_q      <= leftButton;
      r_right_q     <= rightButton;
      r_hold        <= w_hold_nxt;
      r_play_frames <= w_play_nxt;
      r_game_rst    <= w_game_rst_nxt;
      r_start       <= (w_state_nxt == ST_START);
      r_ingame      <= (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_PAUSE);
      r_over        <= (w_state_nxt == ST_OVER);
      r_paused      <= (w_state_nxt == ST_PAUSE);
    end
  end

  assign start_signal    = r_start;
  assign ingame_signal   = r_ingame;
  assign gameover_signal = r_over;
  assign paused          = r_paused;
  assign game_rst        = r_game_rst;
  assign play_frames     = r_play_frames;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed scenarios plus randomized play, every
// cycle compared against a behavioural model of the game rules.
module tb_game_state_ctrl;

  localparam logic [9:0]  X0 = 10'd240;
  localparam logic [9:0]  X1 = 10'd399;
  localparam logic [9:0]  Y0 = 10'd200;
  localparam logic [9:0]  Y1 = 10'd279;
  localparam int          HOLD = 3;

  logic        frame_clk = 1'b0;
  logic        Reset = 1'b0;
  logic        leftButton = 1'b0;
  logic        rightButton = 1'b0;
  logic [9:0]  mouse_x = 10'd0;
  logic [9:0]  mouse_y = 10'd0;
  logic        player_hit = 1'b0;
  logic        start_signal;
  logic        ingame_signal;
  logic        gameover_signal;
  logic        paused;
  logic        game_rst;
  logic [15:0] play_frames;

  game_state_ctrl #(
    .START_X0(X0), .START_X1(X1), .START_Y0(Y0), .START_Y1(Y1),
    .GO_HOLD(16'(HOLD))
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .leftButton(leftButton),
    .rightButton(rightButton),
    .mouse_x(mouse_x),
    .mouse_y(mouse_y),
    .player_hit(player_hit),
    .start_signal(start_signal),
    .ingame_signal(ingame_signal),
    .gameover_signal(gameover_signal),
    .paused(paused),
    .game_rst(game_rst),
    .play_frames(play_frames)
  );

  always #5 frame_clk = ~frame_clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phase, score and hold-off tracked as plain integers.
  localparam int M_TITLE = 0, M_RUN = 1, M_FROZEN = 2, M_OVER = 3;
  int m_mode = M_TITLE;
  int m_score = 0;
  int m_hold = 0;
  bit m_grst = 1'b0;
  bit m_lprev = 1'b1;
  bit m_rprev = 1'b1;
  bit m_lc, m_rc, m_box;

  always @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      m_mode = M_TITLE; m_score = 0; m_hold = 0; m_grst = 1'b0;
      m_lprev = 1'b1; m_rprev = 1'b1;
    end else begin
      m_lc = leftButton && !m_lprev;
      m_rc = rightButton && !m_rprev;
      m_lprev = leftButton;
      m_rprev = rightButton;
      m_box = (int'(mouse_x) >= 240) && (int'(mouse_x) <= 399) &&
              (int'(mouse_y) >= 200) && (int'(mouse_y) <= 279);
      m_grst = 1'b0;
      if (m_mode == M_TITLE) begin
        if (m_lc && m_box) begin m_mode = M_RUN; m_score = 0; m_grst = 1'b1; end
      end else if (m_mode == M_RUN) begin
        m_score = (m_score >= 65535) ? 65535 : m_score + 1;
        if (player_hit) begin m_mode = M_OVER; m_hold = 0; end
        else if (m_rc) m_mode = M_FROZEN;
      end else if (m_mode == M_FROZEN) begin
        if (m_rc) m_mode = M_RUN;
      end else begin
        if (m_lc && m_hold == HOLD) m_mode = M_TITLE;
        else if (m_hold < HOLD) m_hold = m_hold + 1;
      end
    end
  end

  always @(negedge frame_clk) begin
    if (chk_en) begin
      check("start_signal", 32'(start_signal), 32'(m_mode == M_TITLE));
      check("ingame_signal", 32'(ingame_signal), 32'(m_mode == M_RUN || m_mode == M_FROZEN));
      check("gameover_signal", 32'(gameover_signal), 32'(m_mode == M_OVER));
      check("paused", 32'(paused), 32'(m_mode == M_FROZEN));
      check("game_rst", 32'(game_rst), 32'(m_grst));
      check("play_frames", 32'(play_frames), 32'(m_score));
    end
  end

  task automatic tick();
    @(posedge frame_clk);
    #2;
  endtask

  function automatic logic [9:0] pick(input logic [9:0] lo, input logic [9:0] hi);
    case ($urandom_range(0, 5))
      0: pick = lo - 10'd1;
      1: pick = lo;
      2: pick = hi;
      3: pick = hi + 10'd1;
      default: pick = 10'($urandom_range(0, 1023));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    Reset = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_start", 32'(start_signal), 32'd1);
    check("rst_ingame", 32'(ingame_signal), 32'd0);
    check("rst_pf", 32'(play_frames), 32'd0);
    Reset = 1'b1;
    tick();

    // Clicks outside the start box are ignored
    mouse_x = 10'd100; mouse_y = 10'd100; leftButton = 1'b1; tick();
    leftButton = 1'b0; tick();
    mouse_x = 10'd400; mouse_y = 10'd240; leftButton = 1'b1; tick();
    check("outside_start", 32'(start_signal), 32'd1);
    check("outside_grst", 32'(game_rst), 32'd0);
    leftButton = 1'b0; tick();

    // Enter play from the box centre
    mouse_x = 10'd320; mouse_y = 10'd240; leftButton = 1'b1; tick();
    check("enter_ingame", 32'(ingame_signal), 32'd1);
    check("enter_grst", 32'(game_rst), 32'd1);
    check("enter_pf0", 32'(play_frames), 32'd0);
    leftButton = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("count_pf", 32'(play_frames), 32'(i));
      check("count_grst", 32'(game_rst), 32'd0);
    end

    // Pause freezes the score and ignores hits
    repeat (6) tick();
    rightButton = 1'b1; tick();
    check("pause_on", 32'(paused), 32'd1);
    check("pause_pf", 32'(play_frames), 32'd10);
    rightButton = 1'b0; player_hit = 1'b1;
    repeat (5) tick();
    check("pause_hold_pf", 32'(play_frames), 32'd10);
    check("pause_hit_ign", 32'(paused), 32'd1);
    player_hit = 1'b0; rightButton = 1'b1; tick();
    check("resume_paused", 32'(paused), 32'd0);
    check("resume_pf", 32'(play_frames), 32'd10);
    rightButton = 1'b0; tick();
    check("resume_pf11", 32'(play_frames), 32'd11);

    // Hit beats a simultaneous right click
    rightButton = 1'b1; player_hit = 1'b1; tick();
    check("hit_over", 32'(gameover_signal), 32'd1);
    check("hit_paused", 32'(paused), 32'd0);
    check("hit_score", 32'(play_frames), 32'd12);
    rightButton = 1'b0; player_hit = 1'b0;

    // Game-over hold-off then return to start
    tick();
    leftButton = 1'b1; tick();
    check("early_click", 32'(gameover_signal), 32'd1);
    leftButton = 1'b0; tick();
    leftButton = 1'b1; tick();
    check("late_click", 32'(start_signal), 32'd1);
    check("late_score", 32'(play_frames), 32'd12);
    repeat (3) tick();
    check("held_no_play", 32'(start_signal), 32'd1);
    leftButton = 1'b0; tick();

    // Randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) leftButton = ~leftButton;
      if ($urandom_range(0, 4) == 0) rightButton = ~rightButton;
      player_hit = ($urandom_range(0, 15) == 0);
      mouse_x = pick(X0, X1);
      mouse_y = pick(Y0, Y1);
      if ($urandom_range(0, 299) == 0) begin
        Reset = 1'b0; tick(); Reset = 1'b1;
      end
      tick();
    end

    // Long play saturates the score; reset mid-frame clears asynchronously
    leftButton = 1'b0; rightButton = 1'b0; player_hit = 1'b0;
    Reset = 1'b0; tick(); Reset = 1'b1; tick();
    mouse_x = 10'd320; mouse_y = 10'd240; leftButton = 1'b1; tick();
    leftButton = 1'b0;
    repeat (70000) tick();
    check("sat_pf", 32'(play_frames), 32'h0000FFFF);
    check("sat_ingame", 32'(ingame_signal), 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("async_start", 32'(start_signal), 32'd1);
    check("async_ingame", 32'(ingame_signal), 32'd0);
    check("async_over", 32'(gameover_signal), 32'd0);
    check("async_paused", 32'(paused), 32'd0);
    check("async_grst", 32'(game_rst), 32'd0);
    check("async_pf", 32'(play_frames), 32'd0);
    tick();
    Reset = 1'b1;
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
